// File: rtl/simd_pkg.sv
// simd_pkg: shared types, defaults and opcode screening for the SIMD lane packer.
package simd_pkg;
  localparam int NOP_OP_DEF = 0;
  localparam int NUM_VALID_OPS_DEF = 20;
  typedef enum logic {FILL, ISSUE} state_e;
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0] op;
  } lane_req_t;
  function automatic logic is_legal_op(input logic [31:0] op, input int unsigned n);
    return op < n;
  endfunction
endpackage

// File: rtl/simd_lane_packer.sv
// simd_lane_packer: packs scalar ALU requests into SIMD lanes and issues bundles.
// Optional idle-timeout auto-issue enabled by SIMD_PACK_TIMEOUT_EN.
module simd_lane_packer
  import simd_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH = 5,
  parameter int SIMD_WIDTH = 4,
  parameter int NUM_VALID_OPS = NUM_VALID_OPS_DEF,
  parameter int NOP_OP = NOP_OP_DEF,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  output logic in_ready,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  input  logic [OP_WIDTH-1:0] in_op,
  input  logic flush,
  output logic out_valid,
  input  logic out_ready,
  output logic [SIMD_WIDTH*DATA_WIDTH-1:0] operand_a,
  output logic [SIMD_WIDTH*DATA_WIDTH-1:0] operand_b,
  output logic [SIMD_WIDTH*OP_WIDTH-1:0] alu_op,
  output logic [SIMD_WIDTH-1:0] lane_mask,
  output logic [$clog2(SIMD_WIDTH+1)-1:0] lane_count,
  output logic illegal_op,
  output logic error_flag,
  input  logic error_clr
);
  localparam int CW = $clog2(SIMD_WIDTH+1);
  state_e r_state;
  logic [DATA_WIDTH-1:0] r_a [SIMD_WIDTH];
  logic [DATA_WIDTH-1:0] r_b [SIMD_WIDTH];
  logic [OP_WIDTH-1:0] r_op [SIMD_WIDTH];
  logic [SIMD_WIDTH-1:0] r_mask;
  logic [CW-1:0] r_cnt;
  logic r_illegal, r_err;
  logic w_fire, w_acc, w_rej, w_drain, w_issue, w_timeout;
  logic [CW-1:0] w_cnt_next;
  assign in_ready = r_state == FILL;
  assign out_valid = r_state == ISSUE;
  assign w_fire = in_valid & in_ready;
  assign w_acc = w_fire & is_legal_op(32'(in_op), NUM_VALID_OPS);
  assign w_rej = w_fire & ~is_legal_op(32'(in_op), NUM_VALID_OPS);
  assign w_drain = out_valid & out_ready;
  assign w_cnt_next = r_cnt + CW'(w_acc);
  assign w_issue = in_ready & ((w_acc & (w_cnt_next == CW'(SIMD_WIDTH))) | (flush & (w_cnt_next != '0)) | w_timeout);
`ifdef SIMD_PACK_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES+1);
  logic [TW-1:0] r_idle;
  assign w_timeout = ~w_acc & (r_cnt != '0) & (r_idle == TW'(TIMEOUT_CYCLES-1));
  always_ff @(posedge clk)
    if (!rst_n || r_state != FILL || w_acc) r_idle <= '0;
    else if (r_cnt != '0) r_idle <= r_idle + 1'b1;
`else
  assign w_timeout = TIMEOUT_CYCLES < 0;
`endif
  always_ff @(posedge clk) begin
    if (!rst_n || w_drain) begin
      r_state <= FILL;
      r_cnt <= '0;
      r_mask <= '0;
      for (int k = 0; k < SIMD_WIDTH; k++) begin
        r_a[k] <= '0;
        r_b[k] <= '0;
        r_op[k] <= OP_WIDTH'(NOP_OP);
      end
    end else begin
      if (w_issue) r_state <= ISSUE;
      if (w_acc) r_cnt <= w_cnt_next;
      for (int k = 0; k < SIMD_WIDTH; k++)
        if (w_acc && r_cnt == CW'(k)) begin
          r_a[k] <= in_a;
          r_b[k] <= in_b;
          r_op[k] <= in_op;
          r_mask[k] <= 1'b1;
        end
    end
  end
  // a reject in the same cycle as error_clr keeps the flag set
  always_ff @(posedge clk)
    if (!rst_n) begin
      r_illegal <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_illegal <= w_rej;
      r_err <= w_rej | (r_err & ~error_clr);
    end
  for (genvar i = 0; i < SIMD_WIDTH; i++) begin : g_lane
    assign operand_a[i*DATA_WIDTH +: DATA_WIDTH] = r_a[i];
    assign operand_b[i*DATA_WIDTH +: DATA_WIDTH] = r_b[i];
    assign alu_op[i*OP_WIDTH +: OP_WIDTH] = r_op[i];
  end
  assign lane_mask = r_mask;
  assign lane_count = r_cnt;
  assign illegal_op = r_illegal;
  assign error_flag = r_err;
endmodule

// File: tb/tb_simd_lane_packer.sv
// tb_simd_lane_packer: directed stimulus checked against a bundle-level model plus literal expectations.
module tb_simd_lane_packer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0, error_clr = 1'b0;
  logic [31:0] in_a = '0, in_b = '0;
  logic [4:0] in_op = '0;
  logic in_ready, out_valid, illegal_op, error_flag;
  logic [127:0] operand_a, operand_b;
  logic [19:0] alu_op;
  logic [3:0] lane_mask;
  logic [2:0] lane_count;
  int n_checks = 0, n_errors = 0;
  always #5 clk = ~clk;
  simd_lane_packer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .operand_a(operand_a), .operand_b(operand_b), .alu_op(alu_op),
    .lane_mask(lane_mask), .lane_count(lane_count),
    .illegal_op(illegal_op), .error_flag(error_flag), .error_clr(error_clr)
  );
  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // model: the bundle is the list of accepted requests, in arrival order
  logic [31:0] m_a [4], m_b [4];
  logic [4:0] m_op [4];
  int m_n = 0, m_idle = 0;
  bit m_issue = 0, m_ill = 0, m_err = 0, m_live = 0;
  always @(posedge clk) begin : model
    logic [31:0] a [4], b [4];
    logic [4:0] o [4];
    int n, idle;
    bit iss, ill, err, acc;
    a = m_a; b = m_b; o = m_op;
    n = m_n; idle = m_idle; iss = m_issue; ill = 0; acc = 0;
    err = m_err & !error_clr;
    if (!rst_n) begin
      n = 0; iss = 0; err = 0; idle = 0;
    end else if (!m_issue) begin
      if (in_valid && in_op >= 20) begin
        ill = 1; err = 1;
      end else if (in_valid) begin
        a[n] = in_a; b[n] = in_b; o[n] = in_op; n++; acc = 1;
      end
      if (acc) idle = 0;
      else if (n > 0) idle++;
      if (n == 4 || (flush && n > 0)) iss = 1;
`ifdef SIMD_PACK_TIMEOUT_EN
      if (idle == 16) iss = 1;
`endif
    end else if (out_ready) begin
      n = 0; iss = 0; idle = 0;
    end
    m_a <= a; m_b <= b; m_op <= o;
    m_n <= n; m_idle <= idle; m_issue <= iss; m_ill <= ill; m_err <= err;
    if (!rst_n) m_live <= 1;
  end
  always @(negedge clk) begin
    logic [127:0] ea, eb;
    logic [19:0] eo;
    if (m_live) begin
      ea = '0; eb = '0; eo = '0;
      for (int i = 0; i < m_n; i++) begin
        ea[i*32 +: 32] = m_a[i];
        eb[i*32 +: 32] = m_b[i];
        eo[i*5 +: 5] = m_op[i];
      end
      check("out_valid", out_valid, m_issue);
      check("in_ready", in_ready, !m_issue);
      check("lane_count", lane_count, m_n);
      check("lane_mask", lane_mask, (1 << m_n) - 1);
      check("operand_a", operand_a, ea);
      check("operand_b", operand_b, eb);
      check("alu_op", alu_op, eo);
      check("illegal_op", illegal_op, m_ill);
      check("error_flag", error_flag, m_err);
    end
  end
  task automatic cyc(input bit v, input logic [4:0] op, input logic [31:0] a, input bit fl, input bit ordy, input bit clr);
    in_valid = v; in_op = op; in_a = a; in_b = a + 100;
    flush = fl; out_ready = ordy; error_clr = clr;
    @(posedge clk);
    #1;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    check("rst out_valid", out_valid, 0);
    check("rst in_ready", in_ready, 1);
    check("rst lane_count", lane_count, 0);
    check("rst alu_op", alu_op, 0);
    check("rst error_flag", error_flag, 0);
    for (int i = 0; i < 4; i++) cyc(1, 5'(i + 1), 32'(10 + i), 0, 0, 0);
    check("fill out_valid", out_valid, 1);
    check("fill lane_mask", lane_mask, 4'b1111);
    check("fill lane_count", lane_count, 4);
    check("fill alu_op", alu_op, 20'h20C41);
    check("fill operand_a", operand_a, {32'd13, 32'd12, 32'd11, 32'd10});
    for (int i = 0; i < 5; i++) begin
      cyc(1, 7, 99, 0, 0, 0);
      check("bp in_ready", in_ready, 0);
      check("bp alu_op", alu_op, 20'h20C41);
      check("bp operand_b", operand_b, {32'd113, 32'd112, 32'd111, 32'd110});
    end
    cyc(0, 0, 0, 0, 1, 0);
    check("drain in_ready", in_ready, 1);
    check("drain lane_mask", lane_mask, 0);
    cyc(1, 5, 1, 0, 0, 0);
    cyc(1, 6, 2, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    check("partial out_valid", out_valid, 1);
    check("partial lane_mask", lane_mask, 4'b0011);
    check("partial alu_op", alu_op, 20'h000C5);
    check("partial operand_a", operand_a, {64'd0, 32'd2, 32'd1});
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0, 0);
    check("empty flush", out_valid, 0);
    cyc(1, 9, 77, 1, 0, 0);
    check("flush+accept out_valid", out_valid, 1);
    check("flush+accept lane_mask", lane_mask, 4'b0001);
    cyc(1, 3, 5, 1, 0, 0);
    check("flush in ISSUE ignored", lane_count, 1);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(1, 25, 3, 0, 0, 0);
    check("illegal pulse", illegal_op, 1);
    check("illegal flag", error_flag, 1);
    check("illegal not packed", lane_count, 0);
    cyc(0, 0, 0, 0, 0, 0);
    check("illegal pulse end", illegal_op, 0);
    check("flag sticky", error_flag, 1);
    cyc(1, 31, 3, 0, 0, 1);
    check("set wins over clr", error_flag, 1);
    cyc(0, 0, 0, 0, 0, 1);
    check("flag cleared", error_flag, 0);
    cyc(1, 25, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(1, 5'(i + 10), 32'(i), 0, 0, 0);
    check("pre-reset out_valid", out_valid, 1);
    rst_n = 0;
    cyc(0, 0, 0, 0, 0, 0);
    rst_n = 1;
    check("mid-reset out_valid", out_valid, 0);
    check("mid-reset lane_count", lane_count, 0);
    check("mid-reset error_flag", error_flag, 0);
    cyc(1, 3, 42, 0, 0, 0);
    for (int i = 0; i < 16; i++) cyc(0, 0, 0, 0, 0, 0);
`ifdef SIMD_PACK_TIMEOUT_EN
    check("timeout out_valid", out_valid, 1);
`else
    check("no-timeout out_valid", out_valid, 0);
`endif
    check("timeout lane_mask", lane_mask, 4'b0001);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
